// File: rtl/flash_line_prefetch_wb.sv
// -----------------------------------------------------------------------------
// flash_line_prefetch_wb
// One-line read-prefetch buffer sitting between the CPU-side Wishbone bus and
// the spimemio_wb flash port. A read hit is answered one cycle after the
// request. A read miss first pulls the whole aligned line from flash, one word
// per downstream transaction, and only then answers the CPU. This way,
// sequential instruction fetch costs one SPI burst per line rather than one per
// word. Writes are acknowledged and dropped.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | waiting for an upstream request; hits and writes are answered here
// FILL  | fetching line words 0..LINE_WORDS-1 from flash, one transaction each
// RESP  | line is complete; answer the pending read if the master still waits
// -----------------------------------------------------------------------------
module flash_line_prefetch_wb #(
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    input  logic             wb_we_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic             wb_ack_o,
    output logic [31:0]      wb_dat_o,
    output logic             flash_cyc_o,
    output logic             flash_stb_o,
    output logic [31:0]      flash_adr_o,
    input  logic             flash_ack_i,
    input  logic [31:0]      flash_dat_i,
    input  logic             invalidate_i,
    output logic [CNT_W-1:0] hit_count_o
);

    localparam int OFS   = $clog2(LINE_WORDS);
    localparam int TAG_W = 30 - OFS;

    localparam logic [OFS-1:0]   K_LAST  = OFS'(LINE_WORDS - 1);
    localparam logic [OFS-1:0]   K_ONE   = OFS'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // line storage and its bookkeeping
    logic [31:0]      r_line [LINE_WORDS];
    logic [TAG_W-1:0] r_tag;
    logic [OFS-1:0]   r_idx;
    logic [OFS-1:0]   r_k;
    logic             r_valid;
    logic             r_inv_pend;

    // registered outputs
    logic             r_ack;
    logic [31:0]      r_dat;
    logic             r_fcyc;
    logic             r_fstb;
    logic [CNT_W-1:0] r_hits;

    // request decode
    logic             w_req;
    logic [TAG_W-1:0] w_tag;
    logic [OFS-1:0]   w_idx;
    logic             w_tag_hit;
    logic             w_wr;
    logic             w_hit;
    logic             w_miss;
    logic             w_word_ack;
    logic             w_last;
    logic             w_fill_done;
    logic             w_resp_ack;
    logic             w_unused;

    // byte lanes, write data and the byte offset play no part in a word-wide read buffer
    assign w_unused = ^{wb_sel_i, wb_dat_i, wb_adr_i[1:0]};

    assign w_req   = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_tag   = wb_adr_i[31:2+OFS];
    assign w_idx   = wb_adr_i[1+OFS:2];

    // An invalidate on the same cycle as a lookup wins, so the lookup misses.
    assign w_tag_hit = r_valid & (r_tag == w_tag) & ~invalidate_i;

    assign w_wr   = (r_state == ST_IDLE) & w_req &  wb_we_i;
    assign w_hit  = (r_state == ST_IDLE) & w_req & ~wb_we_i &  w_tag_hit;
    assign w_miss = (r_state == ST_IDLE) & w_req & ~wb_we_i & ~w_tag_hit;

    assign w_word_ack  = (r_state == ST_FILL) & r_fstb & flash_ack_i;
    assign w_last      = (r_k == K_LAST);
    assign w_fill_done = w_word_ack & w_last;

    // The master may have given up while the line was filling. In that case no ack goes out.
    assign w_resp_ack = (r_state == ST_RESP) & wb_cyc_i & wb_stb_i;

    // state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_miss) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_fill_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // upstream ack pulse and read data; data holds between acks
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= 32'h0;
        end else begin
            r_ack <= w_wr | w_hit | w_resp_ack;
            if (w_hit) begin
                r_dat <= r_line[w_idx];
            end else if (w_resp_ack) begin
                r_dat <= r_line[r_idx];
            end
        end
    end

    // saturating count of hit acks
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_hits <= '0;
        end else if (w_hit && (r_hits != {CNT_W{1'b1}})) begin
            r_hits <= r_hits + CNT_ONE;
        end
    end

    // line tag, pending index and validity; an invalidate seen during a fill is remembered
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tag      <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_inv_pend <= 1'b0;
        end else if (w_miss) begin
            r_tag      <= w_tag;
            r_idx      <= w_idx;
            r_valid    <= 1'b0;
            r_inv_pend <= 1'b0;
        end else if (w_fill_done) begin
            r_valid    <= ~(r_inv_pend | invalidate_i);
            r_inv_pend <= 1'b0;
        end else if (invalidate_i) begin
            r_valid <= 1'b0;
            if (r_state == ST_FILL) begin
                r_inv_pend <= 1'b1;
            end
        end
    end

    // downstream sequencing: strobe per word, one idle cycle between words, cyc across the line
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_fcyc <= 1'b0;
            r_fstb <= 1'b0;
            r_k    <= '0;
        end else if (w_miss) begin
            r_fcyc <= 1'b1;
            r_fstb <= 1'b1;
            r_k    <= '0;
        end else if (r_state == ST_FILL) begin
            if (w_word_ack) begin
                r_fstb <= 1'b0;
                if (w_last) begin
                    r_fcyc <= 1'b0;
                end else begin
                    r_k <= r_k + K_ONE;
                end
            end else if (r_fcyc && !r_fstb) begin
                r_fstb <= 1'b1;
            end
        end
    end

    // capture each returned flash word into its slot of the line
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && w_word_ack) begin
            r_line[r_k] <= flash_dat_i;
        end
    end

    assign wb_ack_o    = r_ack;
    assign wb_dat_o    = r_dat;
    assign flash_cyc_o = r_fcyc;
    assign flash_stb_o = r_fstb;
    assign flash_adr_o = {r_tag, r_k, 2'b00};
    assign hit_count_o = r_hits;

endmodule
